// File: rtl/pwm_frame_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_frame_sequencer
//
// Double-buffered duty-cycle store for a 24-channel PWM display (8 digits x
// 3 groups l/m/r). The host writes duty values into a shadow bank. A commit
// is applied on the next display frame boundary. The shadow bank is either
// copied straight into the active bank, or the active bank is ramped toward
// the captured target one fade step every FADE_DIV frame ticks.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   wr_valid    host write request
//   wr_ready    write accepted this cycle (IDLE/PENDING only)
//   wr_addr     channel index 0..23 (digit = addr/3, group = addr%3)
//   wr_data     duty value for the addressed channel
//   commit      one-cycle request to apply shadow -> active
//   fade_en     ramp (1) or immediate copy (0), sampled when the commit applies
//   fade_step   per-step maximum change per channel, sampled with fade_en
//   frame_tick  one-cycle frame boundary pulse
//   pwm_bus     active bank, channel n at bits [8n+7:8n]
//   busy        commit pending or fade in progress
//   done        one-cycle pulse while active bank equals the captured target
//   wr_err      one-cycle pulse, one cycle after an accepted write to addr > 23
//   state_dbg   current FSM state (0 IDLE, 1 PENDING, 2 COPY, 3 FADE)
//
// Handshake: a write transfers on a rising edge where wr_valid & wr_ready are
// both 1; wr_ready depends only on the registered state, never on wr_valid.
// -----------------------------------------------------------------------------
module pwm_frame_sequencer #(
    parameter int FADE_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         commit,
    input  logic         fade_en,
    input  logic [7:0]   fade_step,
    input  logic         frame_tick,
    output logic [191:0] pwm_bus,
    output logic         busy,
    output logic         done,
    output logic         wr_err,
    output logic [1:0]   state_dbg
);

    localparam int NCH = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2,
        FADE    = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] shadow      [NCH];
    logic [7:0] active      [NCH];
    logic [7:0] target      [NCH];
    logic [7:0] shadow_next [NCH];
    logic [7:0] fade_next   [NCH];
    logic [7:0] step_q;
    logic [7:0] div_q;
    logic       wr_fire;
    logic       all_eq;
    logic       div_wrap;

    // Move cur toward tgt by at most stp. The distance is taken in 9 bits, and
    // cur +/- stp is only used when the distance exceeds stp, so the result
    // can neither overshoot the target nor wrap past 0 or 255.
    function automatic logic [7:0] approach(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] stp);
        logic [8:0] gap;
        approach = tgt;
        if (tgt > cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            if (gap > {1'b0, stp}) approach = cur + stp;
        end else begin
            gap = {1'b0, cur} - {1'b0, tgt};
            if (gap > {1'b0, stp}) approach = cur - stp;
        end
    endfunction

    assign wr_ready  = (state == IDLE) || (state == PENDING);
    assign wr_fire   = wr_valid && wr_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == COPY) || ((state == FADE) && all_eq);
    assign state_dbg = state;
    assign div_wrap  = (div_q == 8'(FADE_DIV - 1));

    // Shadow contents including a write accepted this cycle, so the value
    // written in the PENDING-exit cycle lands in the target bank.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_next[i] = shadow[i];
            if (wr_fire && (wr_addr == 5'(i))) shadow_next[i] = wr_data;
            fade_next[i] = approach(active[i], target[i], step_q);
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (active[i] != target[i]) all_eq = 1'b0;
        end
    end

    always_comb begin
        pwm_bus = '0;
        for (int i = 0; i < NCH; i++) pwm_bus[8*i +: 8] = active[i];
    end

    // The latched fade enable is represented by the COPY/FADE choice made on
    // leaving PENDING; only the step size needs its own register.
    // For an immediate copy the active bank is loaded together with the
    // target, so the copied values are visible during the COPY cycle, which
    // is the cycle done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            step_q <= '0;
            div_q  <= '0;
            wr_err <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                target[i] <= '0;
            end
        end else begin
            wr_err <= wr_fire && (wr_addr > 5'd23);
            if (wr_fire && (wr_addr <= 5'd23)) shadow[wr_addr] <= wr_data;

            case (state)
                IDLE: begin
                    if (commit) state <= PENDING;
                end
                PENDING: begin
                    if (frame_tick) begin
                        step_q <= fade_step;
                        div_q  <= '0;
                        for (int i = 0; i < NCH; i++) target[i] <= shadow_next[i];
                        if (fade_en && (fade_step != 8'd0)) begin
                            state <= FADE;
                        end else begin
                            for (int i = 0; i < NCH; i++) active[i] <= shadow_next[i];
                            state <= COPY;
                        end
                    end
                end
                COPY: begin
                    state <= IDLE;
                end
                FADE: begin
                    if (all_eq) begin
                        state <= IDLE;
                    end else if (frame_tick) begin
                        if (div_wrap) begin
                            div_q <= '0;
                            for (int i = 0; i < NCH; i++) active[i] <= fade_next[i];
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
